// File: rtl/data_mem_bank_if.sv
// rtl/data_mem_bank_if.sv - request/response bus between the CPU data port and data_mem_bank
//
// Signals:
//   CS        master -> bank  request valid, held until DataReady is seen
//   RW        master -> bank  1 = write, 0 = read
//   BE[3:0]   master -> bank  byte-lane enables, BE[i] selects bits 8i+7:8i
//   Addr      master -> bank  word address (byte-address bits 31:2)
//   DataIn    master -> bank  write data
//   DataOut   bank -> master  registered read data
//   DataReady bank -> master  one-cycle completion pulse
//   DataErr   bank -> master  valid with DataReady, 1 = address out of range
//   Busy      bank -> master  1 while the post-reset clear sweep runs
interface data_mem_bank_if;
    logic        CS;
    logic        RW;
    logic [3:0]  BE;
    logic [31:2] Addr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        DataReady;
    logic        DataErr;
    logic        Busy;

    modport master (
        output CS, RW, BE, Addr, DataIn,
        input  DataOut, DataReady, DataErr, Busy
    );

    modport slave (
        input  CS, RW, BE, Addr, DataIn,
        output DataOut, DataReady, DataErr, Busy
    );
endinterface

// File: rtl/data_mem_bank.sv
// rtl/data_mem_bank.sv - word-organised data memory with wait states, byte lanes and range check
//
// Parameters:
//   ADDR_W   word-address bits, depth = 2**ADDR_W words of 32 bits (1..29)
//   LATENCY  wait cycles inserted before each access (0..15)
// Ports:
//   Clk      clock, all state on the rising edge
//   Reset    asynchronous active-low reset
//   bus      data_mem_bank_if slave modport (CS/RW request, DataReady completion)
module data_mem_bank #(
    parameter int ADDR_W  = 5,
    parameter int LATENCY = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    data_mem_bank_if.slave  bus
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [3:0]        LAT      = 4'(LATENCY);

    typedef enum logic [1:0] {INIT, IDLE, WAIT, ACCESS} state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] clr_idx;

    logic [31:2]       req_addr;
    logic [3:0]        req_be;
    logic              req_rw;
    logic [31:0]       req_data;

    logic [31:0]       data_out;
    logic              data_ready;
    logic              data_err;

    logic [31:0]       mem [0:DEPTH-1];

    logic              accept;
    logic              req_oor;
    logic [ADDR_W-1:0] req_idx;
    logic [31:0]       lane_mask;
    logic [31:0]       rd_word;

    // The mandatory ACCESS cycle between WAIT and IDLE means a held CS is
    // only re-sampled at the edge that ends the DataReady cycle.
    assign accept    = (state == IDLE) && bus.CS;
    assign req_oor   = |req_addr[31:ADDR_W+2];
    assign req_idx   = req_addr[ADDR_W+1:2];
    assign lane_mask = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
    assign rd_word   = req_oor ? 32'h0 : (mem[req_idx] & lane_mask);

    assign bus.DataOut   = data_out;
    assign bus.DataReady = data_ready;
    assign bus.DataErr   = data_err;
    assign bus.Busy      = (state == INIT);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (clr_idx == LAST_IDX) state_next = IDLE;
            IDLE:    if (bus.CS) state_next = WAIT;
            WAIT:    if (wait_cnt == 4'd0) state_next = ACCESS;
            ACCESS:  state_next = IDLE;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wait_cnt   <= 4'd0;
            clr_idx    <= '0;
            req_addr   <= '0;
            req_be     <= 4'h0;
            req_rw     <= 1'b0;
            req_data   <= 32'h0;
            data_out   <= 32'h0;
            data_ready <= 1'b0;
            data_err   <= 1'b0;
        end else begin
            if (state == INIT) begin
                clr_idx <= clr_idx + 1'b1;
            end

            if (accept) begin
                wait_cnt <= LAT;
                req_addr <= bus.Addr;
                req_be   <= bus.BE;
                req_rw   <= bus.RW;
                req_data <= bus.DataIn;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            data_ready <= (state == ACCESS);
            data_err   <= (state == ACCESS) && req_oor;

            if (state == ACCESS && !req_rw) begin
                data_out <= rd_word;
            end
        end
    end

    // Storage has no reset of its own: the INIT sweep clears it, and any
    // asserted Reset forces the state out of ACCESS so no request write lands.
    always_ff @(posedge Clk) begin
        if (state == INIT) begin
            mem[clr_idx] <= 32'h0;
        end else if (state == ACCESS && req_rw && !req_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    mem[req_idx][8*i +: 8] <= req_data[8*i +: 8];
                end
            end
        end
    end

endmodule
